// File: rtl/seg7_digit_decoder.sv
// Receive-side 7-segment pattern decoder: synchronises the segment bus,
// debounces it, classifies each newly stable pattern and reports it once.
module seg7_digit_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         seg_in,
  output logic [3:0]         digit_bin,
  output logic [7:0]         digit_onehot,
  output logic               valid,
  output logic               err,
  output logic               all_flag,
  output logic [COUNT_W-1:0] evt_count
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LOCKED
  } state_t;

  state_t           state;
  logic [7:0]       sync_1;
  logic [7:0]       s;
  logic [7:0]       cand;
  logic [7:0]       committed;
  logic [CNT_W-1:0] cnt;

  logic [3:0]       cls_digit;
  logic             cls_all;
  logic             cls_blank;

  // Classify the candidate pattern into digit 1..8, ALL, BLANK or error.
  always_comb begin
    cls_digit = 4'd0;
    cls_all   = 1'b0;
    cls_blank = 1'b0;
    case (cand)
      8'h06:   cls_digit = 4'd1;
      8'h5B:   cls_digit = 4'd2;
      8'h4F:   cls_digit = 4'd3;
      8'h66:   cls_digit = 4'd4;
      8'h6D:   cls_digit = 4'd5;
      8'h7D:   cls_digit = 4'd6;
      8'h07:   cls_digit = 4'd7;
      8'h7F:   cls_digit = 4'd8;
      8'hFF:   cls_all   = 1'b1;
      8'h00:   cls_blank = 1'b1;
      default: ;
    endcase
  end

  // Synchroniser, debounce FSM and registered commit of the classified pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1       <= '0;
      s            <= '0;
      cand         <= '0;
      committed    <= '0;
      cnt          <= '0;
      state        <= IDLE;
      digit_bin    <= '0;
      digit_onehot <= '0;
      valid        <= 1'b0;
      err          <= 1'b0;
      all_flag     <= 1'b0;
      evt_count    <= '0;
    end else begin
      sync_1 <= seg_in;
      s      <= sync_1;
      valid  <= 1'b0;

      if (s != cand) begin
        cand  <= s;
        cnt   <= '0;
        state <= SETTLE;
      end else if (state == SETTLE && 32'(cnt) < STABLE_CYCLES - 1) begin
        cnt <= cnt + CNT_W'(1);
      end else if (state == SETTLE) begin
        // A pattern that settles back onto the committed value is not an event.
        if (cand != committed) begin
          committed <= cand;
          state     <= LOCKED;
          if (cls_digit != 4'd0) begin
            digit_bin    <= cls_digit;
            digit_onehot <= 8'b1 << (cls_digit - 4'd1);
            err          <= 1'b0;
            all_flag     <= 1'b0;
            valid        <= 1'b1;
            evt_count    <= evt_count + COUNT_W'(1);
          end else if (cls_all) begin
            digit_bin    <= '0;
            digit_onehot <= '1;
            err          <= 1'b0;
            all_flag     <= 1'b1;
            valid        <= 1'b1;
            evt_count    <= evt_count + COUNT_W'(1);
          end else begin
            digit_bin    <= '0;
            digit_onehot <= '0;
            all_flag     <= 1'b0;
            err          <= !cls_blank;
          end
        end else begin
          state <= IDLE;
        end
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_seg7_digit_decoder.sv
// Directed self-checking bench for seg7_digit_decoder (default parameters).
module tb_seg7_digit_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] seg_in = 8'h00;
  logic [3:0] digit_bin;
  logic [7:0] digit_onehot;
  logic       valid;
  logic       err;
  logic       all_flag;
  logic [7:0] evt_count;

  int total = 0;
  int bad   = 0;

  seg7_digit_decoder #(.STABLE_CYCLES(4), .COUNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .seg_in       (seg_in),
    .digit_bin    (digit_bin),
    .digit_onehot (digit_onehot),
    .valid        (valid),
    .err          (err),
    .all_flag     (all_flag),
    .evt_count    (evt_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    seg_in = 8'h00;
    rst    = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Drive a value for n edges and count valid pulses seen.
  task automatic hold(input logic [7:0] v, input int n, output int pulses);
    seg_in = v;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (valid === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset();
    seg_in = 8'h00;
    rst    = 1'b1;
    tick();
    tick();
    total++;
    if ({digit_bin, digit_onehot, valid, err, all_flag, evt_count} !== 23'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0",
               {digit_bin, digit_onehot, valid, err, all_flag, evt_count});
    end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    int p;
    do_reset();
    hold(8'h4F, 6, p);
    total++;
    if (p !== 0) begin bad++; $display("FAIL latency_early got=%0d exp=0", p); end
    tick();
    total++;
    if (valid !== 1'b1) begin bad++; $display("FAIL latency_valid_e7 got=%b exp=1", valid); end
    total++;
    if (digit_bin !== 4'd3) begin bad++; $display("FAIL latency_digit got=%0d exp=3", digit_bin); end
    total++;
    if (digit_onehot !== 8'h04) begin bad++; $display("FAIL latency_onehot got=%h exp=04", digit_onehot); end
    total++;
    if (evt_count !== 8'd1) begin bad++; $display("FAIL latency_count got=%0d exp=1", evt_count); end
    tick();
    total++;
    if (valid !== 1'b0) begin bad++; $display("FAIL latency_pulse_width got=%b exp=0", valid); end
  endtask

  task automatic test_table();
    logic [7:0] pats [8] = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F};
    logic [7:0] oh   [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    int p;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      hold(pats[i], 10, p);
      total++;
      if (p !== 1 || digit_bin !== 4'(i + 1) || digit_onehot !== oh[i] || err !== 1'b0) begin
        bad++;
        $display("FAIL table_%0d got pulses=%0d bin=%0d oh=%h err=%b exp pulses=1 bin=%0d oh=%h err=0",
                 i + 1, p, digit_bin, digit_onehot, err, i + 1, oh[i]);
      end
      hold(8'h00, 10, p);
    end
    total++;
    if (evt_count !== 8'd8) begin bad++; $display("FAIL table_count got=%0d exp=8", evt_count); end
  endtask

  task automatic test_repress();
    int p, sum;
    do_reset();
    sum = 0;
    hold(8'h00, 10, p); sum += p;
    hold(8'h7F, 10, p); sum += p;
    hold(8'h00, 10, p); sum += p;
    total++;
    if (digit_bin !== 4'd0 || digit_onehot !== 8'h00) begin
      bad++; $display("FAIL repress_blank got bin=%0d oh=%h exp 0/00", digit_bin, digit_onehot);
    end
    hold(8'h7F, 10, p); sum += p;
    total++;
    if (sum !== 2) begin bad++; $display("FAIL repress_pulses got=%0d exp=2", sum); end
    total++;
    if (digit_bin !== 4'd8) begin bad++; $display("FAIL repress_digit got=%0d exp=8", digit_bin); end
    total++;
    if (evt_count !== 8'd2) begin bad++; $display("FAIL repress_count got=%0d exp=2", evt_count); end
  endtask

  task automatic test_glitch();
    int p;
    do_reset();
    hold(8'h06, 10, p);
    hold(8'h5B, 2, p);
    hold(8'h06, 12, p);
    total++;
    if (p !== 0) begin bad++; $display("FAIL glitch_pulses got=%0d exp=0", p); end
    total++;
    if (digit_bin !== 4'd1 || digit_onehot !== 8'h01 || evt_count !== 8'd1) begin
      bad++;
      $display("FAIL glitch_outputs got bin=%0d oh=%h cnt=%0d exp 1/01/1", digit_bin, digit_onehot, evt_count);
    end
  endtask

  task automatic test_all_err();
    int p;
    do_reset();
    hold(8'hFF, 10, p);
    total++;
    if (p !== 1 || all_flag !== 1'b1 || digit_onehot !== 8'hFF || digit_bin !== 4'd0 || err !== 1'b0) begin
      bad++;
      $display("FAIL all_pattern got pulses=%0d all=%b oh=%h bin=%0d err=%b exp 1/1/ff/0/0",
               p, all_flag, digit_onehot, digit_bin, err);
    end
    hold(8'h0F, 10, p);
    total++;
    if (p !== 0 || err !== 1'b1 || all_flag !== 1'b0 || digit_onehot !== 8'h00 || evt_count !== 8'd1) begin
      bad++;
      $display("FAIL err_pattern got pulses=%0d err=%b all=%b oh=%h cnt=%0d exp 0/1/0/00/1",
               p, err, all_flag, digit_onehot, evt_count);
    end
    hold(8'h86, 10, p);
    total++;
    if (p !== 0 || err !== 1'b1) begin
      bad++; $display("FAIL err_dp got pulses=%0d err=%b exp 0/1", p, err);
    end
    hold(8'h00, 10, p);
    total++;
    if (err !== 1'b0 || p !== 0) begin
      bad++; $display("FAIL err_clear got err=%b pulses=%0d exp 0/0", err, p);
    end
  endtask

  task automatic test_back_to_back();
    int p, sum;
    do_reset();
    hold(8'h06, 10, p); sum = p;
    hold(8'h5B, 10, p); sum += p;
    total++;
    if (sum !== 2 || digit_bin !== 4'd2 || digit_onehot !== 8'h02) begin
      bad++;
      $display("FAIL back_to_back got pulses=%0d bin=%0d oh=%h exp 2/2/02", sum, digit_bin, digit_onehot);
    end
  endtask

  task automatic test_wrap();
    int p, sum;
    do_reset();
    sum = 0;
    for (int i = 0; i < 256; i++) begin
      hold(8'h00, 8, p); sum += p;
      hold(8'h07, 8, p); sum += p;
    end
    total++;
    if (sum !== 256) begin bad++; $display("FAIL wrap_pulses got=%0d exp=256", sum); end
    total++;
    if (evt_count !== 8'd0) begin bad++; $display("FAIL wrap_count got=%0d exp=0", evt_count); end
    total++;
    if (digit_bin !== 4'd7) begin bad++; $display("FAIL wrap_digit got=%0d exp=7", digit_bin); end
  endtask

  task automatic test_mid_reset();
    int p;
    do_reset();
    hold(8'h06, 10, p);
    hold(8'h66, 4, p);
    rst = 1'b1;
    tick();
    total++;
    if ({digit_bin, digit_onehot, valid, err, all_flag, evt_count} !== 23'd0) begin
      bad++;
      $display("FAIL midrst_outputs got=%h exp=0",
               {digit_bin, digit_onehot, valid, err, all_flag, evt_count});
    end
    rst = 1'b0;
    hold(8'h66, 6, p);
    total++;
    if (p !== 0) begin bad++; $display("FAIL midrst_early got=%0d exp=0", p); end
    tick();
    total++;
    if (valid !== 1'b1 || digit_bin !== 4'd4 || digit_onehot !== 8'h08 || evt_count !== 8'd1) begin
      bad++;
      $display("FAIL midrst_commit got v=%b bin=%0d oh=%h cnt=%0d exp 1/4/08/1",
               valid, digit_bin, digit_onehot, evt_count);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_table();
    test_repress();
    test_glitch();
    test_all_err();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
